// File: rtl/comp_pkg.sv
// Shared types and sizes for the 2-bit comparator self-test.
// Holds the sequencer state encoding and the golden-result bundle.
package comp_pkg;
    localparam int VEC_W   = 4;
    localparam int NUM_VEC = 16;
    localparam int OP_W    = 2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_CHECK,
        ST_DONE
    } state_t;

    typedef struct packed {
        logic gt;
        logic eq;
        logic lt;
    } cmp_res_t;
endpackage

// File: rtl/comp_ref.sv
// Golden 2-bit magnitude comparator; purely combinational, zero latency.
// No flow control: output follows a/b in the same cycle.
module comp_ref
    import comp_pkg::*;
(
    input  logic [OP_W-1:0] a,
    input  logic [OP_W-1:0] b,
    output cmp_res_t        res
);
    always_comb begin
        res.gt = (a > b);
        res.eq = (a == b);
        res.lt = (a < b);
    end
endmodule

// File: rtl/comp_bist.sv
// Sweeps all 16 operand pairs into an external comparator and scores its results.
// Latency: 16*(SETTLE+1) cycles per sweep; start is ignored while busy, no backpressure.
module comp_bist
    import comp_pkg::*;
#(
    parameter int SETTLE = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    output logic [OP_W-1:0] a,
    output logic [OP_W-1:0] b,
    input  logic            s1,
    input  logic            s2,
    input  logic            s3,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [4:0]      err_count,
    output logic            fail_valid,
    output logic [3:0]      first_fail
);
    state_t           state, state_nxt;
    logic [VEC_W-1:0] vec, vec_nxt;
    logic [3:0]       cnt, cnt_nxt;
    logic [4:0]       err_nxt;
    logic             fv_nxt;
    logic [3:0]       ff_nxt;
    cmp_res_t         golden;
    logic             mismatch;

    // Operands come straight off the vector register, so they are registered and
    // stay frozen on the last vector while DONE holds.
    assign a = vec[VEC_W-1:OP_W];
    assign b = vec[OP_W-1:0];

    comp_ref u_ref (
        .a   (a),
        .b   (b),
        .res (golden)
    );

    // Any bit differing counts, which also catches non-one-hot comparator outputs.
    assign mismatch = ({s1, s2, s3} != {golden.gt, golden.eq, golden.lt});

    assign busy = (state == ST_SETTLE) || (state == ST_CHECK);
    assign done = (state == ST_DONE);
    assign pass = done && (err_count == 5'd0);

    always_comb begin
        state_nxt = state;
        vec_nxt   = vec;
        cnt_nxt   = cnt;
        err_nxt   = err_count;
        fv_nxt    = fail_valid;
        ff_nxt    = first_fail;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_nxt = ST_SETTLE;
                    vec_nxt   = '0;
                    cnt_nxt   = '0;
                    err_nxt   = '0;
                    fv_nxt    = 1'b0;
                    ff_nxt    = '0;
                end
            end
            ST_SETTLE: begin
                if (cnt == 4'(SETTLE - 1)) begin
                    state_nxt = ST_CHECK;
                end else begin
                    cnt_nxt = cnt + 4'd1;
                end
            end
            ST_CHECK: begin
                if (mismatch) begin
                    err_nxt = err_count + 5'd1;
                    if (!fail_valid) begin
                        fv_nxt = 1'b1;
                        ff_nxt = vec;
                    end
                end
                if (vec == VEC_W'(NUM_VEC - 1)) begin
                    state_nxt = ST_DONE;
                end else begin
                    state_nxt = ST_SETTLE;
                    vec_nxt   = vec + 4'd1;
                    cnt_nxt   = '0;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            vec        <= '0;
            cnt        <= '0;
            err_count  <= '0;
            fail_valid <= 1'b0;
            first_fail <= '0;
        end else begin
            state      <= state_nxt;
            vec        <= vec_nxt;
            cnt        <= cnt_nxt;
            err_count  <= err_nxt;
            fail_valid <= fv_nxt;
            first_fail <= ff_nxt;
        end
    end
endmodule

// File: tb/tb_comp_bist.sv
// Directed bench for comp_bist: a faultable comparator model on SETTLE=2,
// and a fault-free one on a SETTLE=1 instance.
module tb_comp_bist;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [1:0] fault = 2'd0;
    logic [1:0] a, b;
    logic       s1, s2, s3;
    logic       busy, done, pass, fail_valid;
    logic [4:0] err_count;
    logic [3:0] first_fail;

    logic       start1 = 1'b0;
    logic [1:0] a1, b1;
    logic       s1_1, s2_1, s3_1;
    logic       busy1, done1, pass1, fail_valid1;
    logic [4:0] err_count1;
    logic [3:0] first_fail1;

    int checks = 0;
    int fails  = 0;
    int n;

    always #5 clk = ~clk;

    // fault 0: correct, 1: s2 stuck at 0, 2: s1/s3 swapped
    assign s1 = (fault == 2'd2) ? (a < b) : (a > b);
    assign s2 = (fault == 2'd1) ? 1'b0 : (a == b);
    assign s3 = (fault == 2'd2) ? (a > b) : (a < b);

    assign s1_1 = (a1 > b1);
    assign s2_1 = (a1 == b1);
    assign s3_1 = (a1 < b1);

    comp_bist #(.SETTLE(2)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .s1(s1), .s2(s2), .s3(s3), .busy(busy), .done(done), .pass(pass),
        .err_count(err_count), .fail_valid(fail_valid), .first_fail(first_fail)
    );

    comp_bist #(.SETTLE(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1),
        .s1(s1_1), .s2(s2_1), .s3(s3_1), .busy(busy1), .done(done1), .pass(pass1),
        .err_count(err_count1), .fail_valid(fail_valid1), .first_fail(first_fail1)
    );

    // Returns #1 after the edge that samples start, i.e. in sweep cycle 0.
    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(inout int cyc);
        while (!done && cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({busy, done, pass, fail_valid} !== 4'b0000) begin
            fails++;
            $display("FAIL reset_flags got %b want 0000", {busy, done, pass, fail_valid});
        end
        checks++;
        if ({a, b, err_count, first_fail} !== 13'd0) begin
            fails++;
            $display("FAIL reset_values got a=%0d b=%0d err=%0d ff=%0d want all 0", a, b, err_count, first_fail);
        end
        rst = 1'b0;
        start = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL idle_no_start busy=%b want 0", busy);
        end
    endtask

    task automatic test_good_sweep();
        fault = 2'd0;
        pulse_start();
        checks++;
        if (busy !== 1'b1 || {a, b} !== 4'd0) begin
            fails++;
            $display("FAIL good_first_cycle busy=%b ab=%0d want busy=1 ab=0", busy, {a, b});
        end
        n = 0;
        wait_done(n);
        checks++;
        if (n !== 48) begin
            fails++;
            $display("FAIL good_latency got %0d want 48", n);
        end
        checks++;
        if ({pass, fail_valid, err_count, busy} !== {1'b1, 1'b0, 5'd0, 1'b0}) begin
            fails++;
            $display("FAIL good_result pass=%b fv=%b err=%0d busy=%b want 1 0 0 0", pass, fail_valid, err_count, busy);
        end
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if ({done, a, b, err_count} !== {1'b1, 2'd3, 2'd3, 5'd0}) begin
            fails++;
            $display("FAIL done_hold done=%b a=%0d b=%0d err=%0d want 1 3 3 0", done, a, b, err_count);
        end
    endtask

    task automatic test_s2_stuck();
        fault = 2'd1;
        pulse_start();
        n = 0;
        wait_done(n);
        checks++;
        if ({err_count, first_fail, pass, fail_valid} !== {5'd4, 4'b0000, 1'b0, 1'b1}) begin
            fails++;
            $display("FAIL s2_stuck err=%0d ff=%b pass=%b fv=%b want 4 0000 0 1", err_count, first_fail, pass, fail_valid);
        end
    endtask

    task automatic test_swap_restart();
        fault = 2'd2;
        pulse_start();
        repeat (9) @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        n = 10;
        checks++;
        if ({a, b} !== 4'd3) begin
            fails++;
            $display("FAIL midsweep_start ab=%0d want 3", {a, b});
        end
        wait_done(n);
        checks++;
        if (n !== 48) begin
            fails++;
            $display("FAIL swap_latency got %0d want 48", n);
        end
        checks++;
        if ({err_count, first_fail, pass} !== {5'd12, 4'b0001, 1'b0}) begin
            fails++;
            $display("FAIL swap_result err=%0d ff=%b pass=%b want 12 0001 0", err_count, first_fail, pass);
        end
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        checks++;
        if ({busy, done, fail_valid, err_count, first_fail, a, b} !== {1'b1, 1'b0, 1'b0, 5'd0, 4'd0, 2'd0, 2'd0}) begin
            fails++;
            $display("FAIL done_restart busy=%b done=%b fv=%b err=%0d ff=%0d ab=%0d want 1 0 0 0 0 0",
                     busy, done, fail_valid, err_count, first_fail, {a, b});
        end
        n = 0;
        wait_done(n);
        checks++;
        if (n !== 48 || err_count !== 5'd12) begin
            fails++;
            $display("FAIL restart_sweep cycles=%0d err=%0d want 48 12", n, err_count);
        end
    endtask

    task automatic test_mid_reset();
        fault = 2'd1;
        pulse_start();
        repeat (23) @(posedge clk);
        #1;
        checks++;
        if ({a, b, busy} !== {2'd1, 2'd3, 1'b1} || err_count !== 5'd2) begin
            fails++;
            $display("FAIL vec7_check a=%0d b=%0d busy=%b err=%0d want 1 3 1 2", a, b, busy, err_count);
        end
        rst = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        start = 1'b0;
        checks++;
        if ({busy, done, a, b, err_count, fail_valid} !== 11'd0) begin
            fails++;
            $display("FAIL mid_reset busy=%b done=%b a=%0d b=%0d err=%0d fv=%b want all 0",
                     busy, done, a, b, err_count, fail_valid);
        end
        fault = 2'd0;
        pulse_start();
        n = 0;
        wait_done(n);
        checks++;
        if (n !== 48 || pass !== 1'b1) begin
            fails++;
            $display("FAIL post_reset_sweep cycles=%0d pass=%b want 48 1", n, pass);
        end
    endtask

    task automatic test_settle1();
        @(negedge clk);
        start1 = 1'b1;
        @(posedge clk);
        #1;
        start1 = 1'b0;
        for (int v = 0; v < 16; v++) begin
            checks++;
            if ({a1, b1} !== 4'(v) || done1 !== 1'b0) begin
                fails++;
                $display("FAIL settle1_step ab=%0d done=%b want %0d 0", {a1, b1}, done1, v);
            end
            repeat (2) @(posedge clk);
            #1;
        end
        checks++;
        if ({done1, pass1, err_count1} !== {1'b1, 1'b1, 5'd0}) begin
            fails++;
            $display("FAIL settle1_done done=%b pass=%b err=%0d want 1 1 0", done1, pass1, err_count1);
        end
    endtask

    initial begin
        test_reset();
        test_good_sweep();
        test_s2_stuck();
        test_swap_restart();
        test_mid_reset();
        test_settle1();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/comp_bist.md
COMP_BIST -- requirements
Module: comp_bist

Interface
REQ-001 SHALL have parameter SETTLE, default 2, giving the number of cycles each vector is held before sampling, legal range 1..15.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst, input, 1, the reset; synchronous and active-high.
REQ-004 SHALL have port start, input, 1, a one-cycle sweep request.
REQ-005 SHALL have port a, output, 2, the registered operand A driven to the comparator under test.
REQ-006 SHALL have port b, output, 2, the registered operand B driven to the comparator under test.
REQ-007 SHALL have ports s1, s2 and s3, each input, 1, the comparator results: s1 means a>b, s2 means a==b, s3 means a<b.
REQ-008 SHALL have port busy, output, 1, high while a sweep is in progress.
REQ-009 SHALL have port done, output, 1, high while the sweep has completed and results are valid.
REQ-010 SHALL have port pass, output, 1, equal to done AND (err_count==0).
REQ-011 SHALL have port err_count, output, 5, the number of mismatching vectors (0..16).
REQ-012 SHALL have port fail_valid, output, 1, high once any mismatch has been captured.
REQ-013 SHALL have port first_fail, output, 4, the vector {a[1],a[0],b[1],b[0]} of the first mismatch.

Function
REQ-014 SHALL keep a 4-bit vector index vec; a=vec[3:2] and b=vec[1:0], so the sweep order is a[1] outermost and b[0] innermost.
REQ-015 SHALL implement the states IDLE, SETTLE, CHECK and DONE.
REQ-016 IDLE SHALL move to SETTLE when start=1, with vec=0, settle counter=0, err_count=0, fail_valid=0 and first_fail=0.
REQ-017 SETTLE SHALL last exactly SETTLE cycles with a and b stable, then move to CHECK.
REQ-018 CHECK SHALL last one cycle, sample s1/s2/s3, and compare them against the golden values {a>b, a==b, a<b}.
REQ-019 On any mismatch in any bit, including a non-one-hot result, CHECK SHALL increment err_count by 1.
REQ-020 On a mismatch with fail_valid=0, CHECK SHALL also set fail_valid=1 and first_fail=vec; later mismatches SHALL NOT change first_fail.
REQ-021 CHECK with vec==15 SHALL go to DONE; otherwise it SHALL increment vec and return to SETTLE with the settle counter cleared.
REQ-022 Each vector SHALL take SETTLE+1 cycles, and a full sweep SHALL take 16*(SETTLE+1) cycles from the cycle after start to done=1.
REQ-023 busy SHALL be 1 in SETTLE and CHECK and 0 in IDLE and DONE; done SHALL be 1 only in DONE.
REQ-024 start SHALL be ignored while busy=1.
REQ-025 start in DONE SHALL restart a sweep exactly as from IDLE, clearing all results in that cycle.
REQ-026 DONE SHALL hold a, b and all result outputs stable until start or rst.
REQ-027 vec SHALL NOT wrap: the increment past 15 never occurs, because CHECK at 15 exits to DONE.
REQ-028 err_count SHALL NOT overflow, because it is bounded at 16 by construction.

Reset
REQ-029 rst=1 SHALL, on the next edge, force IDLE, vec=0, a=0, b=0, busy=0, done=0, pass=0, err_count=0, fail_valid=0, first_fail=0 and settle counter=0.
REQ-030 rst SHALL take priority over start, including when both are asserted in the same cycle.
REQ-031 rst asserted mid-sweep SHALL abort the sweep, discard partial results, and leave the block in IDLE waiting for a new start.

Structure
REQ-032 The shared package comp_pkg SHALL hold the state enum, VEC_W=4, NUM_VEC=16 and OP_W=2.
REQ-033 There SHALL be exactly one sub-module, comp_ref: a combinational golden 2-bit comparator producing the expected s1/s2/s3 from a and b.
REQ-034 The sequencer, counters and result registers SHALL live in comp_bist.

Verification
REQ-035 With a correct comparator attached, SETTLE=2 and a start pulse: done SHALL rise exactly 48 cycles later, with pass=1, err_count=0 and fail_valid=0.
REQ-036 With s2 stuck at 0: the sweep SHALL end with err_count=4, first_fail=4'b0000 and pass=0.
REQ-037 With s1 and s3 swapped: the sweep SHALL end with err_count=12 and first_fail=4'b0001.
REQ-038 With rst asserted during vector 7 CHECK: the next cycle SHALL show IDLE, a=b=0 and err_count=0; a following start SHALL complete a normal 48-cycle sweep.
REQ-039 With start pulsed mid-sweep and again in DONE: the mid-sweep pulse SHALL leave the sequence and timing unchanged, and the DONE pulse SHALL clear the results and restart at vec=0.
REQ-040 With SETTLE=1 and a correct comparator: done SHALL rise 32 cycles after start, and a/b SHALL be checked to step 0..15 with no skips.
